// File: rtl/sprite_pkg.sv
// Shared types and defaults for the per-pixel sprite scheduler.
// Holds sprite geometry defaults, the transparent index, coordinate type and sequencer states.
package sprite_pkg;

  localparam int DEF_NUM_SPR = 4;
  localparam int DEF_SPR_W   = 32;
  localparam int DEF_SPR_H   = 32;

  localparam logic [3:0] TRANSPARENT_IDX = 4'h0;

  typedef logic [9:0] coord_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD_A = 2'd1,
    ST_RD_B = 2'd2,
    ST_WAIT = 2'd3
  } seq_state_t;

endpackage

// File: rtl/sprite_hit_check.sv
// Combinational coverage test of one sprite against the current draw pixel.
// Offsets are 11 bits wide so a pixel left of / above the sprite wraps large and misses.
module sprite_hit_check
  import sprite_pkg::*;
#(
  parameter int SPR_W = DEF_SPR_W,
  parameter int SPR_H = DEF_SPR_H
) (
  input  coord_t                     sx,
  input  coord_t                     sy,
  input  logic                       en,
  input  coord_t                     draw_x,
  input  coord_t                     draw_y,
  output logic                       hit,
  output logic [$clog2(SPR_W)-1:0]   dx,
  output logic [$clog2(SPR_H)-1:0]   dy
);

  localparam logic [10:0] W_LIM = 11'(SPR_W);
  localparam logic [10:0] H_LIM = 11'(SPR_H);

  logic [10:0] dx_full;
  logic [10:0] dy_full;

  always_comb begin
    dx_full = {1'b0, draw_x} - {1'b0, sx};
    dy_full = {1'b0, draw_y} - {1'b0, sy};
    hit     = en && (dx_full < W_LIM) && (dy_full < H_LIM);
    dx      = dx_full[$clog2(SPR_W)-1:0];
    dy      = dy_full[$clog2(SPR_H)-1:0];
  end

endmodule

// File: rtl/sprite_pixel_sched.sv
// Per-pixel sprite scheduler: picks the two highest-priority covering sprites, reads
// both from the shared index ROM and composites them over the background, 4-cycle latency.
module sprite_pixel_sched
  import sprite_pkg::*;
#(
  parameter int NUM_SPR = DEF_NUM_SPR,
  parameter int SPR_W   = DEF_SPR_W,
  parameter int SPR_H   = DEF_SPR_H,
  parameter int ADDR_W  = $clog2(NUM_SPR) + $clog2(SPR_W) + $clog2(SPR_H)
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    frame_start,
  input  coord_t [NUM_SPR-1:0]    spr_x,
  input  coord_t [NUM_SPR-1:0]    spr_y,
  input  logic   [NUM_SPR-1:0]    spr_en,
  input  logic                    pix_tick,
  input  coord_t                  DrawX,
  input  coord_t                  DrawY,
  input  logic   [3:0]            bg_index,
  output logic                    rom_rd,
  output logic   [ADDR_W-1:0]     rom_addr,
  input  logic   [3:0]            rom_data,
  output logic                    pix_valid_out,
  output logic   [3:0]            pix_index,
  output logic                    pix_is_sprite,
  output logic                    overrun,
  output seq_state_t              seq_state
);

  localparam int IDW = $clog2(NUM_SPR);
  localparam int XW  = $clog2(SPR_W);
  localparam int YW  = $clog2(SPR_H);

  // Pixel interface: pix_tick is a one-cycle request with no back-pressure; a tick that
  // lands while a read is in progress is dropped and flagged on overrun. pix_valid_out is
  // a one-cycle pulse, exactly four cycles after each accepted tick.

  coord_t [NUM_SPR-1:0]          sh_x;
  coord_t [NUM_SPR-1:0]          sh_y;
  logic   [NUM_SPR-1:0]          sh_en;
  logic   [NUM_SPR-1:0]          hit;
  logic   [NUM_SPR-1:0][XW-1:0]  hdx;
  logic   [NUM_SPR-1:0][YW-1:0]  hdy;

  logic                sel_a_vld;
  logic                sel_b_vld;
  logic [IDW-1:0]      sel_a_id;
  logic [IDW-1:0]      sel_b_id;
  logic [ADDR_W-1:0]   sel_a_addr;
  logic [ADDR_W-1:0]   sel_b_addr;
  logic                start;

  logic                a_vld;
  logic                b_vld;
  logic [ADDR_W-1:0]   b_addr;
  logic [3:0]          data_a;

  // Shadow copies keep a moving sprite from tearing mid-frame.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sh_x  <= '0;
      sh_y  <= '0;
      sh_en <= '0;
    end else if (frame_start) begin
      sh_x  <= spr_x;
      sh_y  <= spr_y;
      sh_en <= spr_en;
    end
  end

  for (genvar g = 0; g < NUM_SPR; g++) begin : g_hit
    sprite_hit_check #(.SPR_W(SPR_W), .SPR_H(SPR_H)) u_hit (
      .sx     (sh_x[g]),
      .sy     (sh_y[g]),
      .en     (sh_en[g]),
      .draw_x (DrawX),
      .draw_y (DrawY),
      .hit    (hit[g]),
      .dx     (hdx[g]),
      .dy     (hdy[g])
    );
  end

  // First and second set bits of the hit vector, lowest index wins.
  always_comb begin
    sel_a_vld = 1'b0;
    sel_b_vld = 1'b0;
    sel_a_id  = '0;
    sel_b_id  = '0;
    for (int i = 0; i < NUM_SPR; i++) begin
      if (hit[i]) begin
        if (!sel_a_vld) begin
          sel_a_vld = 1'b1;
          sel_a_id  = IDW'(i);
        end else if (!sel_b_vld) begin
          sel_b_vld = 1'b1;
          sel_b_id  = IDW'(i);
        end
      end
    end
    sel_a_addr = ADDR_W'({sel_a_id, hdy[sel_a_id], hdx[sel_a_id]});
    sel_b_addr = ADDR_W'({sel_b_id, hdy[sel_b_id], hdx[sel_b_id]});
    start      = pix_tick && (seq_state == ST_IDLE || seq_state == ST_WAIT);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      seq_state     <= ST_IDLE;
      rom_rd        <= 1'b0;
      rom_addr      <= '0;
      a_vld         <= 1'b0;
      b_vld         <= 1'b0;
      b_addr        <= '0;
      data_a        <= '0;
      pix_valid_out <= 1'b0;
      pix_index     <= '0;
      pix_is_sprite <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      rom_rd        <= 1'b0;
      pix_valid_out <= 1'b0;

      if (frame_start) overrun <= 1'b0;
      if (pix_tick && (seq_state == ST_RD_A || seq_state == ST_RD_B)) overrun <= 1'b1;

      if (start) begin
        seq_state <= ST_RD_A;
        a_vld     <= sel_a_vld;
        b_vld     <= sel_b_vld;
        b_addr    <= sel_b_addr;
        rom_rd    <= sel_a_vld;
        if (sel_a_vld) rom_addr <= sel_a_addr;
      end else begin
        case (seq_state)
          ST_RD_A: begin
            seq_state <= ST_RD_B;
            rom_rd    <= b_vld;
            if (b_vld) rom_addr <= b_addr;
          end
          ST_RD_B: begin
            data_a    <= rom_data;
            seq_state <= ST_WAIT;
          end
          default: seq_state <= ST_IDLE;
        endcase
      end

      // In WAIT, rom_data carries slot B's index for the pixel being finished.
      if (seq_state == ST_WAIT) begin
        pix_valid_out <= 1'b1;
        if (a_vld && data_a != TRANSPARENT_IDX) begin
          pix_index     <= data_a;
          pix_is_sprite <= 1'b1;
        end else if (b_vld && rom_data != TRANSPARENT_IDX) begin
          pix_index     <= rom_data;
          pix_is_sprite <= 1'b1;
        end else begin
          pix_index     <= bg_index;
          pix_is_sprite <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sprite_pixel_sched.sv
// Directed plus randomized bench for sprite_pixel_sched with a coverage-list reference
// model, a ROM responder and an expected-queue scoreboard for reads and pixels.
module tb_sprite_pixel_sched;
  import sprite_pkg::*;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int H  = 32;
  localparam int AW = 12;

  logic               Clk = 1'b0;
  logic               Reset_n = 1'b0;
  logic               frame_start = 1'b0;
  coord_t [N-1:0]     spr_x = '0;
  coord_t [N-1:0]     spr_y = '0;
  logic   [N-1:0]     spr_en = '0;
  logic               pix_tick = 1'b0;
  coord_t             DrawX = '0;
  coord_t             DrawY = '0;
  logic   [3:0]       bg_index = '0;
  logic               rom_rd;
  logic   [AW-1:0]    rom_addr;
  logic   [3:0]       rom_data = '0;
  logic               pix_valid_out;
  logic   [3:0]       pix_index;
  logic               pix_is_sprite;
  logic               overrun;
  seq_state_t         seq_state;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [3:0]    mem [0:4095];
  int            m_x [N];
  int            m_y [N];
  bit            m_en[N];
  logic [AW-1:0] exp_rd_q[$];
  int            exp_rd_cyc_q[$];
  logic [4:0]    exp_q[$];
  int            exp_cyc_q[$];
  logic [3:0]    rom_next = '0;

  sprite_pixel_sched #(.NUM_SPR(N), .SPR_W(W), .SPR_H(H), .ADDR_W(AW)) dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .frame_start   (frame_start),
    .spr_x         (spr_x),
    .spr_y         (spr_y),
    .spr_en        (spr_en),
    .pix_tick      (pix_tick),
    .DrawX         (DrawX),
    .DrawY         (DrawY),
    .bg_index      (bg_index),
    .rom_rd        (rom_rd),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .pix_valid_out (pix_valid_out),
    .pix_index     (pix_index),
    .pix_is_sprite (pix_is_sprite),
    .overrun       (overrun),
    .seq_state     (seq_state)
  );

  // clock / cycle counter
  always #10 Clk = ~Clk;
  always @(posedge Clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: list every covering sprite, keep the first two, first opaque wins.
  function automatic void model_pixel(int x, int y, int bg);
    int          ids[$];
    logic [AW-1:0] addr;
    logic [4:0]  res;
    bit          found;
    for (int i = 0; i < N; i++)
      if (m_en[i] && x >= m_x[i] && x < m_x[i] + W && y >= m_y[i] && y < m_y[i] + H)
        ids.push_back(i);
    res   = {1'b0, 4'(bg)};
    found = 1'b0;
    for (int k = 0; k < 2 && k < ids.size(); k++) begin
      addr = AW'(ids[k] * W * H + (y - m_y[ids[k]]) * W + (x - m_x[ids[k]]));
      exp_rd_q.push_back(addr);
      exp_rd_cyc_q.push_back(cyc + 1 + k);
      if (!found && mem[addr] != 4'h0) begin
        found = 1'b1;
        res   = {1'b1, mem[addr]};
      end
    end
    exp_q.push_back(res);
    exp_cyc_q.push_back(cyc + 4);
  endfunction

  // ROM responder: data appears one cycle after the strobe; junk when no read was made.
  initial forever begin
    @(negedge Clk);
    rom_data = rom_next;
    rom_next = rom_rd ? mem[rom_addr] : 4'($urandom_range(0, 15));
  end

  // scoreboard monitor
  initial forever begin
    @(negedge Clk);
    if (Reset_n === 1'b1) begin
      if (rom_rd !== 1'b0) begin
        check("rd_expected", 32'(exp_rd_q.size() > 0), 32'd1);
        if (exp_rd_q.size() > 0) begin
          check("rd_cycle", cyc, exp_rd_cyc_q.pop_front());
          check("rd_addr", 32'(rom_addr), 32'(exp_rd_q.pop_front()));
        end
      end
      if (pix_valid_out !== 1'b0) begin
        check("pix_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          check("pix_cycle", cyc, exp_cyc_q.pop_front());
          check("pix_value", 32'({pix_is_sprite, pix_index}), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // driver tasks
  task automatic drive_cycle(input bit tick, input bit frame, input int x, input int y,
                             input int bg, input bit accept);
    @(negedge Clk);
    pix_tick    = tick;
    frame_start = frame;
    if (tick) begin
      DrawX    = coord_t'(x & 1023);
      DrawY    = coord_t'(y & 1023);
      bg_index = 4'(bg);
      if (accept) model_pixel(x & 1023, y & 1023, bg);
    end
    if (frame)
      for (int i = 0; i < N; i++) begin
        m_x[i]  = int'(spr_x[i]);
        m_y[i]  = int'(spr_y[i]);
        m_en[i] = spr_en[i];
      end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive_cycle(1'b0, 1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic pixel(input int x, input int y, input int bg);
    drive_cycle(1'b1, 1'b0, x, y, bg, 1'b1);
    idle(4);
  endtask

  task automatic new_frame();
    drive_cycle(1'b0, 1'b1, 0, 0, 0, 1'b0);
    idle(1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rom_rd"}, 32'(rom_rd), 32'd0);
    check({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
    check({tag, "_valid"}, 32'(pix_valid_out), 32'd0);
    check({tag, "_index"}, 32'(pix_index), 32'd0);
    check({tag, "_is_sprite"}, 32'(pix_is_sprite), 32'd0);
    check({tag, "_overrun"}, 32'(overrun), 32'd0);
    check({tag, "_state"}, 32'(seq_state), 32'(ST_IDLE));
  endtask

  initial begin
    int bg;
    int gap;
    for (int a = 0; a < 4096; a++) mem[a] = 4'h0;
    for (int i = 0; i < N; i++) begin
      m_x[i] = 0; m_y[i] = 0; m_en[i] = 1'b0;
    end

    // reset state
    repeat (3) @(negedge Clk);
    check_all_zero("reset");
    Reset_n = 1'b1;
    idle(2);

    // sprite live-enabled but no frame_start yet: background only
    spr_x[0] = 10'd100; spr_y[0] = 10'd50; spr_en = 4'b0001;
    mem[12'h045] = 4'h7;
    pixel(105, 52, 5);

    // single sprite hit, address {0,2,5}
    new_frame();
    pixel(105, 52, 1);

    // two layers: top transparent, lower one shows
    spr_x[2] = 10'd90; spr_y[2] = 10'd40;
    spr_x[3] = 10'd100; spr_y[3] = 10'd50; spr_en = 4'b1101;
    mem[12'h045] = 4'h0; mem[12'h98F] = 4'h9; mem[12'hC45] = 4'h6;
    new_frame();
    pixel(105, 52, 1);
    // both visible layers transparent: third sprite stays hidden
    mem[12'h98F] = 4'h0;
    pixel(105, 52, 2);

    // nothing covers the pixel
    pixel(500, 400, 3);

    // right/left edge coverage of a sprite at (620,0)
    spr_x[1] = 10'd620; spr_y[1] = 10'd0; spr_en = 4'b0010;
    for (int a = 1024; a < 2048; a++) mem[a] = 4'(a % 15 + 1);
    new_frame();
    pixel(651, 0, 4);
    pixel(619, 0, 4);
    pixel(652, 0, 4);
    pixel(651, 31, 4);
    pixel(651, 32, 4);

    // live move without frame_start: shadow still rules
    spr_x[1] = 10'd300;
    pixel(651, 0, 4);
    pixel(305, 0, 4);
    new_frame();
    pixel(305, 0, 4);

    // frame_start together with a tick: old shadow for this pixel
    spr_x[1] = 10'd700;
    drive_cycle(1'b1, 1'b1, 305, 0, 6, 1'b1);
    idle(4);
    pixel(705, 0, 6);

    // back-to-back tick in WAIT
    drive_cycle(1'b1, 1'b0, 710, 3, 8, 1'b1);
    idle(2);
    drive_cycle(1'b1, 1'b0, 400, 3, 8, 1'b1);
    idle(5);

    // randomized frames
    for (int f = 0; f < 4; f++) begin
      int bx = int'($urandom_range(0, 900));
      int by = int'($urandom_range(0, 440));
      for (int i = 0; i < N; i++) begin
        spr_x[i] = coord_t'(bx + int'($urandom_range(0, 40)));
        spr_y[i] = coord_t'(by + int'($urandom_range(0, 40)));
      end
      spr_en = 4'($urandom_range(1, 15));
      for (int a = 0; a < 4096; a++)
        mem[a] = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      new_frame();
      gap = 4;
      bg  = 0;
      for (int p = 0; p < 40; p++) begin
        int j = int'($urandom_range(0, N - 1));
        int x = int'(spr_x[j]) + int'($urandom_range(0, 44)) - 6;
        int y = int'(spr_y[j]) + int'($urandom_range(0, 44)) - 6;
        if (gap != 3) bg = int'($urandom_range(0, 15));
        drive_cycle(1'b1, 1'b0, x, y, bg, 1'b1);
        gap = int'($urandom_range(3, 5));
        idle(gap - 1);
      end
      idle(5);
    end

    // overrun: second tick lands in RD_A and is dropped
    spr_x[0] = 10'd100; spr_y[0] = 10'd50; spr_en = 4'b0001;
    mem[12'h045] = 4'hA;
    new_frame();
    check("ovr_before", 32'(overrun), 32'd0);
    drive_cycle(1'b1, 1'b0, 105, 52, 4, 1'b1);
    drive_cycle(1'b1, 1'b0, 105, 52, 4, 1'b0);
    drive_cycle(1'b0, 1'b0, 0, 0, 0, 1'b0);
    check("ovr_set", 32'(overrun), 32'd1);
    idle(6);
    check("ovr_hold", 32'(overrun), 32'd1);
    drive_cycle(1'b0, 1'b1, 0, 0, 0, 1'b0);
    drive_cycle(1'b0, 1'b0, 0, 0, 0, 1'b0);
    check("ovr_clear", 32'(overrun), 32'd0);

    // reset with a pixel in flight
    drive_cycle(1'b1, 1'b0, 105, 52, 4, 1'b1);
    drive_cycle(1'b1, 1'b0, 105, 52, 4, 1'b0);
    @(negedge Clk);
    pix_tick = 1'b0;
    #2 Reset_n = 1'b0;
    exp_rd_q.delete(); exp_rd_cyc_q.delete(); exp_q.delete(); exp_cyc_q.delete();
    for (int i = 0; i < N; i++) begin
      m_x[i] = 0; m_y[i] = 0; m_en[i] = 1'b0;
    end
    #1 check_all_zero("midrst");
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    idle(8);
    // after reset: background until a frame_start
    pixel(105, 52, 9);
    new_frame();
    pixel(105, 52, 9);

    idle(4);
    check("rd_q_empty", 32'(exp_rd_q.size()), 32'd0);
    check("pix_q_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
